// File: rtl/dmem_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_arbiter_if
//  Description : Bus bundle between the two data-memory masters, the
//                dmem_arbiter and the 16K x 32 data SRAM port.
//  Revision    : 1.0 - initial release
// ============================================================================

interface dmem_arbiter_if #(
    parameter int unsigned ADDR_W = 14
);
    // Master 0 (CPU load/store unit)
    logic              m0_req;
    logic              m0_we;
    logic [ADDR_W-1:0] m0_addr;
    logic [31:0]       m0_wdata;
    logic [3:0]        m0_wstrb;
    logic              m0_gnt;
    logic              m0_rvalid;
    logic [31:0]       m0_rdata;
    logic              m0_err;

    // Master 1 (DMA / crypto engine)
    logic              m1_req;
    logic              m1_we;
    logic [ADDR_W-1:0] m1_addr;
    logic [31:0]       m1_wdata;
    logic [3:0]        m1_wstrb;
    logic              m1_gnt;
    logic              m1_rvalid;
    logic [31:0]       m1_rdata;
    logic              m1_err;

    // Single SRAM port
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [3:0]        mem_wstrb;
    logic [31:0]       mem_rdata;

    // Arbiter side
    modport slave (
        input  m0_req, m0_we, m0_addr, m0_wdata, m0_wstrb,
        output m0_gnt, m0_rvalid, m0_rdata, m0_err,
        input  m1_req, m1_we, m1_addr, m1_wdata, m1_wstrb,
        output m1_gnt, m1_rvalid, m1_rdata, m1_err,
        output mem_we, mem_addr, mem_wdata, mem_wstrb,
        input  mem_rdata
    );

    // Requester / SRAM side
    modport master (
        output m0_req, m0_we, m0_addr, m0_wdata, m0_wstrb,
        input  m0_gnt, m0_rvalid, m0_rdata, m0_err,
        output m1_req, m1_we, m1_addr, m1_wdata, m1_wstrb,
        input  m1_gnt, m1_rvalid, m1_rdata, m1_err,
        input  mem_we, mem_addr, mem_wdata, mem_wstrb,
        output mem_rdata
    );
endinterface

`default_nettype wire

// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_arbiter
//  Description : Two-master arbiter for the 64KB data SRAM. Master 0 wins
//                ties until master 1 has waited MAX_BURST grants; responses
//                return one cycle after accept. Define DMEM_ARB_PROT_EN to
//                block master 1 from word addresses below PROT_LIMIT.
//  Revision    : 1.0 - initial release
// ============================================================================

module dmem_arbiter #(
    parameter int unsigned       ADDR_W     = 14,
    parameter int unsigned       MAX_BURST  = 4,
    parameter logic [ADDR_W-1:0] PROT_LIMIT = 14'h0400
) (
    input  logic          clk,
    input  logic          rst_n,
    dmem_arbiter_if.slave bus
);

    localparam logic [3:0] c_max_burst = 4'(MAX_BURST);

    typedef enum logic [1:0] {
        RESP_NONE = 2'd0,
        RESP_R0   = 2'd1,
        RESP_R1   = 2'd2
    } resp_t;

    // A zero limit would make the secure window empty, which is almost
    // certainly a misconfiguration rather than an intent.
    generate
        if (MAX_BURST < 1 || MAX_BURST > 15 || PROT_LIMIT == '0) begin : g_param_check
            $error("dmem_arbiter: MAX_BURST must be 1..15 and PROT_LIMIT nonzero");
        end
    endgenerate

    resp_t       r_resp_sel;
    resp_t       w_resp_nxt;
    logic [3:0]  r_burst_cnt;
    logic [31:0] r_rdata;
    logic        w_gnt0;
    logic        w_gnt1;
    logic        w_blocked;
    logic        w_capture;

    // ------------------------------------------------------------------
    // Grant: m0 wins a tie unless m1 has already waited MAX_BURST grants.
    // ------------------------------------------------------------------
    assign w_gnt0 = bus.m0_req & (~bus.m1_req | (r_burst_cnt != c_max_burst));
    assign w_gnt1 = bus.m1_req & ~w_gnt0;

    assign bus.m0_gnt = w_gnt0;
    assign bus.m1_gnt = w_gnt1;

`ifdef DMEM_ARB_PROT_EN
    assign w_blocked = w_gnt1 & (bus.m1_addr < PROT_LIMIT);
`else
    assign w_blocked = 1'b0;
`endif

    // Only a non-blocked read brings SRAM data back; writes return zero.
    assign w_capture = (w_gnt0 & ~bus.m0_we) | (w_gnt1 & ~bus.m1_we & ~w_blocked);

    // ------------------------------------------------------------------
    // SRAM port drive
    // ------------------------------------------------------------------
    always_comb begin
        bus.mem_we    = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        bus.mem_wstrb = '0;
        if (w_gnt0) begin
            bus.mem_we    = bus.m0_we;
            bus.mem_addr  = bus.m0_addr;
            bus.mem_wdata = bus.m0_wdata;
            bus.mem_wstrb = bus.m0_wstrb;
        end else if (w_gnt1) begin
            bus.mem_we    = bus.m1_we & ~w_blocked;
            bus.mem_addr  = bus.m1_addr;
            bus.mem_wdata = bus.m1_wdata;
            bus.mem_wstrb = bus.m1_wstrb;
        end
    end

    // ------------------------------------------------------------------
    // Starvation counter: m0 grants taken while m1 is waiting
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_burst_cnt <= '0;
        end else if (!bus.m1_req || w_gnt1) begin
            r_burst_cnt <= '0;
        end else if (w_gnt0 && (r_burst_cnt != c_max_burst)) begin
            r_burst_cnt <= r_burst_cnt + 4'd1;
        end
    end

    // ------------------------------------------------------------------
    // Response FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_resp_sel <= RESP_NONE;
            r_rdata    <= '0;
        end else begin
            r_resp_sel <= w_resp_nxt;
            r_rdata    <= w_capture ? bus.mem_rdata : 32'h0;
        end
    end

    always_comb begin
        w_resp_nxt     = RESP_NONE;
        bus.m0_rvalid  = 1'b0;
        bus.m0_rdata   = '0;
        bus.m1_rvalid  = 1'b0;
        bus.m1_rdata   = '0;

        if (w_gnt0) begin
            w_resp_nxt = RESP_R0;
        end else if (w_gnt1) begin
            w_resp_nxt = RESP_R1;
        end

        case (r_resp_sel)
            RESP_R0: begin
                bus.m0_rvalid = 1'b1;
                bus.m0_rdata  = r_rdata;
            end
            RESP_R1: begin
                bus.m1_rvalid = 1'b1;
                bus.m1_rdata  = r_rdata;
            end
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // Error flags: only m1 can ever be blocked
    // ------------------------------------------------------------------
    assign bus.m0_err = 1'b0;

`ifdef DMEM_ARB_PROT_EN
    logic r_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err <= 1'b0;
        end else begin
            r_err <= w_blocked;
        end
    end

    assign bus.m1_err = (r_resp_sel == RESP_R1) & r_err;
`else
    assign bus.m1_err = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dmem_arbiter
//  Description : Self-checking bench for dmem_arbiter with an SRAM model and
//                a behavioural reference for randomized two-master traffic.
//  Revision    : 1.0 - initial release
// ============================================================================

module tb_dmem_arbiter;

    localparam int unsigned ADDR_W     = 14;
    localparam int unsigned MAX_BURST  = 4;
    localparam logic [13:0] PROT_LIMIT = 14'h0400;
`ifdef DMEM_ARB_PROT_EN
    localparam bit PROT = 1'b1;
`else
    localparam bit PROT = 1'b0;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;

    dmem_arbiter_if #(.ADDR_W(ADDR_W)) bus ();

    dmem_arbiter #(
        .ADDR_W    (ADDR_W),
        .MAX_BURST (MAX_BURST),
        .PROT_LIMIT(PROT_LIMIT)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    // SRAM: synchronous byte-masked write, combinational read
    logic [31:0] sram    [0:16383];
    logic [31:0] ref_mem [0:16383];

    assign bus.mem_rdata = sram[bus.mem_addr];

    always @(posedge clk) begin
        if (bus.mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (bus.mem_wstrb[b]) sram[bus.mem_addr][8*b +: 8] = bus.mem_wdata[8*b +: 8];
            end
        end
    end

    // Samples: grant/SRAM side before the edge, responses just after it
    logic        s_gnt0, s_gnt1, s_mem_we;
    logic [13:0] s_mem_addr;
    logic        s_rv0, s_rv1, s_err0, s_err1;
    logic [31:0] s_rd0, s_rd1;

    task automatic clk_cycle();
        @(negedge clk);
        s_gnt0     = bus.m0_gnt;
        s_gnt1     = bus.m1_gnt;
        s_mem_we   = bus.mem_we;
        s_mem_addr = bus.mem_addr;
        @(posedge clk);
        #1;
        s_rv0  = bus.m0_rvalid;
        s_rd0  = bus.m0_rdata;
        s_err0 = bus.m0_err;
        s_rv1  = bus.m1_rvalid;
        s_rd1  = bus.m1_rdata;
        s_err1 = bus.m1_err;
    endtask

    task automatic drive(input bit m, input bit req, input bit we, input logic [13:0] a,
                         input logic [31:0] d, input logic [3:0] s);
        if (!m) begin
            bus.m0_req = req; bus.m0_we = we; bus.m0_addr = a; bus.m0_wdata = d; bus.m0_wstrb = s;
        end else begin
            bus.m1_req = req; bus.m1_we = we; bus.m1_addr = a; bus.m1_wdata = d; bus.m1_wstrb = s;
        end
    endtask

    // Single access by one master; returns the response sampled after accept
    task automatic access(input bit m, input bit we, input logic [13:0] a, input logic [31:0] d,
                          input logic [3:0] s, output bit acc, output logic rv,
                          output logic [31:0] rd, output logic er, output int ncyc);
        acc  = 1'b0;
        ncyc = 0;
        drive(m, 1'b1, we, a, d, s);
        for (int n = 0; n < 20 && !acc; n++) begin
            clk_cycle();
            ncyc++;
            acc = m ? s_gnt1 : s_gnt0;
        end
        drive(m, 1'b0, 1'b0, '0, '0, '0);
        rv = m ? s_rv1 : s_rv0;
        rd = m ? s_rd1 : s_rd0;
        er = m ? s_err1 : s_err0;
    endtask

    task automatic test_reset();
        drive(0, 0, 0, '0, '0, '0);
        drive(1, 0, 0, '0, '0, '0);
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_tests++;
        if ({bus.m0_rvalid, bus.m1_rvalid, bus.m0_err, bus.m1_err} !== 4'b0) begin
            n_fail++; $display("FAIL reset_flags: got %b expected 0000",
                               {bus.m0_rvalid, bus.m1_rvalid, bus.m0_err, bus.m1_err});
        end
        n_tests++;
        if ({bus.m0_rdata, bus.m1_rdata} !== 64'h0) begin
            n_fail++; $display("FAIL reset_rdata: got %h expected 0", {bus.m0_rdata, bus.m1_rdata});
        end
        n_tests++;
        if ({bus.m0_gnt, bus.m1_gnt, bus.mem_we, bus.mem_addr} !== 17'h0) begin
            n_fail++; $display("FAIL reset_idle_bus: got %h expected 0",
                               {bus.m0_gnt, bus.m1_gnt, bus.mem_we, bus.mem_addr});
        end
        rst_n = 1'b1;
    endtask

    task automatic test_write_read();
        bit acc; logic rv, er; logic [31:0] rd; int nc;
        access(0, 1, 14'd5, 32'hDEADBEEF, 4'hF, acc, rv, rd, er, nc);
        n_tests++;
        if ({acc, rv, rd} !== {2'b11, 32'h0}) begin
            n_fail++; $display("FAIL wr_ack: got acc=%b rv=%b rd=%h expected 1 1 0", acc, rv, rd);
        end
        access(0, 0, 14'd5, 32'h0, 4'h0, acc, rv, rd, er, nc);
        n_tests++;
        if ({acc, rv, er, nc} !== {3'b110, 32'd1}) begin
            n_fail++; $display("FAIL rd_latency: got acc=%b rv=%b err=%b cyc=%0d expected 1 1 0 1", acc, rv, er, nc);
        end
        n_tests++;
        if (rd !== 32'hDEADBEEF) begin
            n_fail++; $display("FAIL rd_data: got %h expected deadbeef", rd);
        end
    endtask

    task automatic test_fairness();
        logic [9:0] got, expv;
        for (int i = 0; i < 10; i++) expv[i] = ((i + 1) % (MAX_BURST + 1)) == 0;
        drive(0, 1, 0, 14'h100, '0, '0);
        drive(1, 1, 0, 14'h101, '0, '0);
        for (int i = 0; i < 10; i++) begin
            clk_cycle();
            got[i] = s_gnt1;
            n_tests++;
            if (s_gnt0 === s_gnt1) begin
                n_fail++; $display("FAIL one_gnt[%0d]: got gnt0=%b gnt1=%b expected exactly one", i, s_gnt0, s_gnt1);
            end
            n_tests++;
            if ({s_rv1, s_rv0} !== {s_gnt1, s_gnt0}) begin
                n_fail++; $display("FAIL fair_rvalid[%0d]: got %b expected %b", i, {s_rv1, s_rv0}, {s_gnt1, s_gnt0});
            end
        end
        drive(0, 0, 0, '0, '0, '0);
        drive(1, 0, 0, '0, '0, '0);
        n_tests++;
        if (got !== expv) begin
            n_fail++; $display("FAIL fair_order: got %b expected %b (bit i = m1 won accept i)", got, expv);
        end
    endtask

    task automatic test_strobe();
        bit acc; logic rv, er; logic [31:0] rd; int nc;
        access(0, 1, 14'h20, 32'h11223344, 4'hF, acc, rv, rd, er, nc);
        access(1, 1, 14'h20, 32'h0000AB00, 4'b0010, acc, rv, rd, er, nc);
        access(1, 0, 14'h20, '0, '0, acc, rv, rd, er, nc);
        n_tests++;
        if ({rv, er, rd} !== {2'b10, 32'h1122AB44}) begin
            n_fail++; $display("FAIL strobe_rb: got rv=%b err=%b rd=%h expected 1 0 1122ab44", rv, er, rd);
        end
        access(1, 1, 14'h20, 32'hFFFFFFFF, 4'b0000, acc, rv, rd, er, nc);
        n_tests++;
        if ({acc, rv} !== 2'b11) begin
            n_fail++; $display("FAIL strobe0_ack: got acc=%b rv=%b expected 1 1", acc, rv);
        end
        access(0, 0, 14'h20, '0, '0, acc, rv, rd, er, nc);
        n_tests++;
        if (rd !== 32'h1122AB44) begin
            n_fail++; $display("FAIL strobe0_rb: got %h expected 1122ab44", rd);
        end
    endtask

    task automatic test_prot();
        bit acc; logic rv, er; logic [31:0] rd; int nc;
        access(0, 1, 14'h0010, 32'h12345678, 4'hF, acc, rv, rd, er, nc);
        access(1, 1, 14'h0010, 32'hCAFEF00D, 4'hF, acc, rv, rd, er, nc);
        n_tests++;
        if (s_mem_we !== !PROT) begin
            n_fail++; $display("FAIL prot_mem_we: got %b expected %b", s_mem_we, !PROT);
        end
        n_tests++;
        if ({acc, rv, er, rd} !== {2'b11, PROT, 32'h0}) begin
            n_fail++; $display("FAIL prot_wr_resp: got acc=%b rv=%b err=%b rd=%h expected 1 1 %b 0", acc, rv, er, rd, PROT);
        end
        access(0, 0, 14'h0010, '0, '0, acc, rv, rd, er, nc);
        n_tests++;
        if (rd !== (PROT ? 32'h12345678 : 32'hCAFEF00D)) begin
            n_fail++; $display("FAIL prot_m0_rb: got %h expected %h", rd, PROT ? 32'h12345678 : 32'hCAFEF00D);
        end
        // Boundary: last secure word and first open word
        access(0, 1, 14'h03FF, 32'h5A5A5A5A, 4'hF, acc, rv, rd, er, nc);
        access(0, 1, 14'h0400, 32'h0BADF00D, 4'hF, acc, rv, rd, er, nc);
        access(1, 0, 14'h03FF, '0, '0, acc, rv, rd, er, nc);
        n_tests++;
        if ({rv, er, rd} !== {1'b1, PROT, (PROT ? 32'h0 : 32'h5A5A5A5A)}) begin
            n_fail++; $display("FAIL prot_3ff: got rv=%b err=%b rd=%h expected 1 %b %h", rv, er, rd, PROT, PROT ? 32'h0 : 32'h5A5A5A5A);
        end
        access(1, 0, 14'h0400, '0, '0, acc, rv, rd, er, nc);
        n_tests++;
        if ({rv, er, rd} !== {2'b10, 32'h0BADF00D}) begin
            n_fail++; $display("FAIL prot_400: got rv=%b err=%b rd=%h expected 1 0 0badf00d", rv, er, rd);
        end
    endtask

    task automatic test_reset_mid();
        bit acc; logic rv, er; logic [31:0] rd; int nc;
        logic [4:0] got;
        drive(0, 1, 0, 14'd5, '0, '0);
        drive(1, 1, 0, 14'h500, '0, '0);
        clk_cycle();
        clk_cycle();
        n_tests++;
        if ({s_gnt0, s_gnt1} !== 2'b10) begin
            n_fail++; $display("FAIL rstmid_pre: got gnt0=%b gnt1=%b expected 1 0", s_gnt0, s_gnt1);
        end
        rst_n = 1'b0;
        drive(0, 0, 0, '0, '0, '0);
        drive(1, 0, 0, '0, '0, '0);
        #1;
        n_tests++;
        if ({bus.m0_rvalid, bus.m1_rvalid, bus.m0_err, bus.m1_err, bus.m0_gnt, bus.m1_gnt, bus.mem_we} !== 7'b0 ||
            {bus.m0_rdata, bus.m1_rdata, bus.mem_addr} !== 78'h0) begin
            n_fail++; $display("FAIL rstmid_outs: got rv0=%b rv1=%b rd0=%h mem_we=%b expected all 0",
                               bus.m0_rvalid, bus.m1_rvalid, bus.m0_rdata, bus.mem_we);
        end
        for (int i = 0; i < 2; i++) begin
            clk_cycle();
            n_tests++;
            if ({s_rv0, s_rv1} !== 2'b00) begin
                n_fail++; $display("FAIL rstmid_norv[%0d]: got %b expected 00", i, {s_rv0, s_rv1});
            end
        end
        rst_n = 1'b1;
        // Cleared starvation count shows up as a full MAX_BURST run before m1
        drive(0, 1, 0, 14'h101, '0, '0);
        drive(1, 1, 0, 14'h102, '0, '0);
        for (int i = 0; i < 5; i++) begin
            clk_cycle();
            got[i] = s_gnt1;
        end
        drive(0, 0, 0, '0, '0, '0);
        drive(1, 0, 0, '0, '0, '0);
        n_tests++;
        if (got !== 5'b10000) begin
            n_fail++; $display("FAIL rstmid_burst: got %b expected 10000", got);
        end
        access(0, 0, 14'd5, '0, '0, acc, rv, rd, er, nc);
        n_tests++;
        if ({acc, rv, nc, rd} !== {2'b11, 32'd1, 32'hDEADBEEF}) begin
            n_fail++; $display("FAIL rstmid_read: got acc=%b rv=%b cyc=%0d rd=%h expected 1 1 1 deadbeef", acc, rv, nc, rd);
        end
    endtask

    task automatic test_m1_stream();
        int ng, nr;
        for (int pass = 0; pass < 2; pass++) begin
            ng = 0; nr = 0;
            for (int i = 0; i < 10; i++) begin
                drive(1, 1, pass == 0, 14'(14'h500 + i), 32'hA5000000 | i, 4'hF);
                clk_cycle();
                ng += int'(s_gnt1);
                nr += int'(s_rv1);
                if (pass == 1) begin
                    n_tests++;
                    if ({s_rv1, s_rd1} !== {1'b1, 32'hA5000000 | i}) begin
                        n_fail++; $display("FAIL stream_rd[%0d]: got rv=%b rd=%h expected 1 %h", i, s_rv1, s_rd1, 32'hA5000000 | i);
                    end
                end
            end
            drive(1, 0, 0, '0, '0, '0);
            n_tests++;
            if ({ng, nr} !== {32'd10, 32'd10}) begin
                n_fail++; $display("FAIL stream_count[%0d]: got gnt=%0d rvalid=%0d expected 10 10", pass, ng, nr);
            end
        end
    endtask

    function automatic logic [13:0] pick_addr();
        logic [13:0] base;
        base = ($urandom_range(0, 1) == 0) ? 14'h03E0 : 14'h0420;
        return base + 14'($urandom_range(0, 15));
    endfunction

    task automatic test_random();
        bit p0 = 0, p1 = 0, blk;
        logic we0 = 0, we1 = 0;
        logic [13:0] a0 = '0, a1 = '0, exp_addr;
        logic [31:0] d0 = '0, d1 = '0, exp_rd;
        logic [3:0] st0 = '0, st1 = '0;
        logic exp_we;
        int win, waited = 0;
        for (int c = 0; c < 400; c++) begin
            if (!p0 && $urandom_range(0, 3) != 0) begin
                p0 = 1; we0 = 1'($urandom_range(0, 1)); a0 = pick_addr(); d0 = $urandom; st0 = 4'($urandom_range(0, 15));
            end
            if (!p1 && $urandom_range(0, 3) != 0) begin
                p1 = 1; we1 = 1'($urandom_range(0, 1)); a1 = pick_addr(); d1 = $urandom; st1 = 4'($urandom_range(0, 15));
            end
            drive(0, p0, we0, a0, d0, st0);
            drive(1, p1, we1, a1, d1, st1);

            // m1 is served once it has watched MAX_BURST m0 wins in a row
            if (p0 && p1) win = (waited >= MAX_BURST) ? 1 : 0;
            else if (p0)  win = 0;
            else if (p1)  win = 1;
            else          win = -1;
            blk      = PROT && win == 1 && a1 < PROT_LIMIT;
            exp_we   = (win == 0) ? we0 : (win == 1) ? (we1 & !blk) : 1'b0;
            exp_addr = (win == 0) ? a0 : (win == 1) ? a1 : 14'h0;
            exp_rd   = 32'h0;
            if (win == 0 && !we0) exp_rd = ref_mem[a0];
            if (win == 1 && !we1 && !blk) exp_rd = ref_mem[a1];

            clk_cycle();

            n_tests++;
            if ({s_gnt1, s_gnt0} !== {win == 1, win == 0}) begin
                n_fail++; $display("FAIL rnd_gnt[%0d]: got %b expected %b", c, {s_gnt1, s_gnt0}, {win == 1, win == 0});
            end
            n_tests++;
            if ({s_mem_we, s_mem_addr} !== {exp_we, exp_addr}) begin
                n_fail++; $display("FAIL rnd_mem[%0d]: got we=%b addr=%h expected we=%b addr=%h", c, s_mem_we, s_mem_addr, exp_we, exp_addr);
            end
            n_tests++;
            if ({s_rv1, s_rv0} !== {win == 1, win == 0}) begin
                n_fail++; $display("FAIL rnd_rvalid[%0d]: got %b expected %b", c, {s_rv1, s_rv0}, {win == 1, win == 0});
            end
            if (win >= 0) begin
                n_tests++;
                if ((win == 0 && {s_rd0, s_err0} !== {exp_rd, 1'b0}) ||
                    (win == 1 && {s_rd1, s_err1} !== {exp_rd, blk})) begin
                    n_fail++; $display("FAIL rnd_resp[%0d]: m%0d got rd=%h err=%b expected rd=%h err=%b", c, win,
                                       win == 0 ? s_rd0 : s_rd1, win == 0 ? s_err0 : s_err1, exp_rd, blk);
                end
            end

            if (win == 0 && we0)
                for (int b = 0; b < 4; b++) if (st0[b]) ref_mem[a0][8*b +: 8] = d0[8*b +: 8];
            if (win == 1 && we1 && !blk)
                for (int b = 0; b < 4; b++) if (st1[b]) ref_mem[a1][8*b +: 8] = d1[8*b +: 8];

            if (!p1 || win == 1) waited = 0;
            else if (win == 0)   waited++;
            if (win == 0) p0 = 0;
            if (win == 1) p1 = 0;
        end
        drive(0, 0, 0, '0, '0, '0);
        drive(1, 0, 0, '0, '0, '0);
    endtask

    initial begin
        for (int i = 0; i < 16384; i++) begin
            sram[i]    = 32'h0;
            ref_mem[i] = 32'h0;
        end
        test_reset();
        test_write_read();
        test_fairness();
        test_strobe();
        test_prot();
        test_reset_mid();
        test_m1_stream();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
